// File: rtl/adder_share_pkg.sv
// Shared definitions for the adder-sharing arbiter: datapath widths and FSM states.
package adder_share_pkg;

   localparam int DATA_W = 32;
   localparam int SUM_W  = 33;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      RESP = 2'd2
   } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: lowest set valid bit at or above ptr, else lowest set bit overall.
module rr_arbiter #(
   parameter int N_REQ = 4,
   parameter int ID_W  = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] valid,
   input  logic [ID_W-1:0]  ptr,
   output logic [N_REQ-1:0] grant,
   output logic [ID_W-1:0]  winner,
   output logic             any
);

   logic [N_REQ-1:0] upper;
   logic [N_REQ-1:0] pick_vec;

   // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
   always_comb begin
      upper    = '0;
      pick_vec = '0;
      grant    = '0;
      winner   = '0;
      any      = |valid;

      for (int i = 0; i < N_REQ; i++) begin
         upper[i] = valid[i] && (i >= int'(ptr));
      end

      // Requests at or above the pointer take precedence; otherwise the search has wrapped.
      pick_vec = (|upper) ? upper : valid;

      // Scanning downward leaves the lowest set bit as the final assignment.
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (pick_vec[i]) begin
            grant    = '0;
            grant[i] = 1'b1;
            winner   = ID_W'(i);
         end
      end
   end

endmodule

// File: rtl/adder_share_arbiter.sv
// Round-robin sequencer sharing one external 32-bit adder among N_REQ requesters,
// returning the registered 33-bit sum with the owner's ID over one response handshake.
module adder_share_arbiter
   import adder_share_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int ID_W  = $clog2(N_REQ),
   parameter int CNT_W = 16
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic [N_REQ-1:0]        req_valid_i,
   output logic [N_REQ-1:0]        req_ready_o,
   input  logic [N_REQ*DATA_W-1:0] req_a_i,
   input  logic [N_REQ*DATA_W-1:0] req_b_i,
   output logic [DATA_W-1:0]       add1_o,
   output logic [DATA_W-1:0]       add2_o,
   input  logic [SUM_W-1:0]        sum_i,
   output logic                    rsp_valid_o,
   input  logic                    rsp_ready_i,
   output logic [ID_W-1:0]         rsp_id_o,
   output logic [SUM_W-1:0]        rsp_sum_o,
   output logic                    busy_o,
   output logic [CNT_W-1:0]        ops_done_o
);

   state_e            state_q, state_d;
   logic [ID_W-1:0]   ptr_q;
   logic [DATA_W-1:0] add1_q, add2_q;
   logic [ID_W-1:0]   id_q;
   logic [SUM_W-1:0]  sum_q;
   logic [CNT_W-1:0]  cnt_q;

   logic [N_REQ-1:0]  grant;
   logic [ID_W-1:0]   winner;
   logic              any_valid;
   logic              accept;
   logic              rsp_done;
   logic [ID_W-1:0]   next_ptr;

   logic [DATA_W-1:0] a_arr [N_REQ];
   logic [DATA_W-1:0] b_arr [N_REQ];

   rr_arbiter #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_rr_arbiter (
      .valid  (req_valid_i),
      .ptr    (ptr_q),
      .grant  (grant),
      .winner (winner),
      .any    (any_valid)
   );

   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         a_arr[i] = req_a_i[DATA_W*i +: DATA_W];
         b_arr[i] = req_b_i[DATA_W*i +: DATA_W];
      end
   end

   assign next_ptr = (winner == ID_W'(N_REQ - 1)) ? '0 : winner + ID_W'(1);
   assign rsp_done = (state_q == RESP) && rsp_ready_i;

   always_comb begin
      state_d     = state_q;
      req_ready_o = '0;
      accept      = 1'b0;
      unique case (state_q)
         IDLE: begin
            // Ready is gated by reset so no handshake completes on a resetting edge.
            if (any_valid && rst_ni) begin
               req_ready_o = grant;
               accept      = 1'b1;
               state_d     = CALC;
            end
         end
         CALC:    state_d = RESP;
         RESP:    if (rsp_ready_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         add1_q  <= '0;
         add2_q  <= '0;
         id_q    <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            ptr_q  <= next_ptr;
            add1_q <= a_arr[winner];
            add2_q <= b_arr[winner];
            id_q   <= winner;
         end
         // The adder settles within the CALC cycle; its result is captured at that cycle's end.
         if (state_q == CALC) begin
            sum_q <= sum_i;
         end
         if (rsp_done) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

   assign add1_o      = add1_q;
   assign add2_o      = add2_q;
   assign rsp_valid_o = (state_q == RESP);
   assign rsp_id_o    = id_q;
   assign rsp_sum_o   = sum_q;
   assign busy_o      = (state_q != IDLE);
   assign ops_done_o  = cnt_q;

endmodule
